// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one- or two-word (OD) instructions at the PC,
// pulses IPC/DIPC back to the PC and holds the result in a valid/ready output register.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int OD_BIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  input  logic              bb,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              IPC,
  output logic              DIPC,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_operand,
  output logic              out_od,
  output logic [ADDR_W-1:0] out_pc,
  output logic              dbg_state
);

  // Output handshake: an instruction transfers to decode on a cycle where
  // out_valid and out_ready are both 1; out_* are held stable while out_valid=1
  // and out_ready=0. A new fetch is issued only when the slot is empty or draining.

  typedef enum logic {F1 = 1'b0, F2 = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   first_word_q, first_word_d;
  logic [ADDR_W-1:0]   first_pc_q, first_pc_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_instr_q, out_instr_d;
  logic [DATA_W-1:0]   out_operand_q, out_operand_d;
  logic                out_od_q, out_od_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

  logic                slot_free;
  logic                fire;
  logic                first_is_od;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= F1;
      first_word_q  <= '0;
      first_pc_q    <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_operand_q <= '0;
      out_od_q      <= 1'b0;
      out_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      first_word_q  <= first_word_d;
      first_pc_q    <= first_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_operand_q <= out_operand_d;
      out_od_q      <= out_od_d;
      out_pc_q      <= out_pc_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    first_word_d  = first_word_q;
    first_pc_d    = first_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_operand_d = out_operand_q;
    out_od_d      = out_od_q;
    out_pc_d      = out_pc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      // mem_req is already low, so any mem_ready this cycle cannot fire.
      state_d      = F1;
      out_valid_d  = 1'b0;
      first_word_d = '0;
      first_pc_d   = '0;
    end else if (fire) begin
      unique case (state_q)
        F1: begin
          if (first_is_od) begin
            first_word_d = mem_data;
            first_pc_d   = pc_addr;
            state_d      = F2;
          end else begin
            out_valid_d   = 1'b1;
            out_instr_d   = mem_data;
            out_operand_d = '0;
            out_od_d      = 1'b0;
            out_pc_d      = pc_addr;
          end
        end
        F2: begin
          out_valid_d   = 1'b1;
          out_instr_d   = first_word_q;
          out_operand_d = mem_data;
          out_od_d      = 1'b1;
          out_pc_d      = first_pc_q;
          state_d       = F1;
        end
        default: state_d = F1;
      endcase
    end
  end

  // Outputs
  always_comb begin
    slot_free   = ~out_valid_q | out_ready;
    mem_req     = ~rst & ~flush & ~bb & slot_free;
    fire        = mem_req & mem_ready;
    first_is_od = mem_data[OD_BIT];
    mem_addr    = (state_q == F2) ? pc_addr + ADDR_W'(1) : pc_addr;
    IPC         = fire & (state_q == F1) & ~first_is_od;
    DIPC        = fire & (state_q == F2);
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_operand = out_operand_q;
  assign out_od      = out_od_q;
  assign out_pc      = out_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter: takes the current PC (toAS), fetches one- or two-word (OD) instructions from instruction memory, and returns IPC/DIPC to the PC.
- Holds one fetched instruction in an output register with valid/ready handshake toward decode (PCBuffer1 / stage-2 side).
- Handles flush on branch load (LPC2|LPC3) and bus-busy stall (BB).

Parameters:
- ADDR_W, 16, PC/memory address width
- DATA_W, 16, instruction word width
- OD_BIT, 15, bit of first word that marks a two-word (OD) instruction

Ports:
- clk  in  1  system-wide clock, all state on posedge
- rst  in  1  synchronous active-high reset
- pc_addr  in  ADDR_W  current PC (toAS from PC)
- flush  in  1  LPC2|LPC3: branch load this cycle
- bb  in  1  bus busy from BB module
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  read completes this cycle
- IPC  out  1  increment PC by 1 (combinational, one-cycle pulse)
- DIPC  out  1  increment PC by 2 (combinational, one-cycle pulse)
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  decode accepts the instruction this cycle
- out_instr  out  DATA_W  first instruction word
- out_operand  out  DATA_W  second word (OD only, else 0)
- out_od  out  1  instruction is two-word
- out_pc  out  ADDR_W  address of the first word

Behaviour:
- States: F1 (fetch first word), F2 (fetch OD operand). Reset -> F1.
- Reset: out_valid=0; out_instr, out_operand, out_pc=0; out_od=0; first-word latch=0; mem_req=0, IPC=0, DIPC=0 during the reset cycle.
- slot_free = ~out_valid | out_ready.
- mem_req = ~rst & ~flush & ~bb & slot_free. Memory is single-cycle-capable: mem_data is sampled in the cycle mem_ready=1 with mem_req=1.
- mem_addr = pc_addr in F1, pc_addr+1 in F2 (wraps mod 2^ADDR_W; 0xFFFF+1 = 0x0000).
- F1, mem_ready & mem_req:
  - If mem_data[OD_BIT]=0: load out_instr=mem_data, out_operand=0, out_od=0, out_pc=pc_addr, out_valid=1; IPC=1 in the same cycle; stay F1.
  - If mem_data[OD_BIT]=1: latch the first word and pc_addr; no IPC; go F2.
- F2, mem_ready & mem_req: load out_instr=latched word, out_operand=mem_data, out_od=1, out_pc=latched pc, out_valid=1; DIPC=1 in the same cycle; go F1.
- IPC and DIPC are never both 1, and are asserted only when mem_req=1 (this implies bb=0).
- Output handshake: out_valid & out_ready clears out_valid unless a new load happens in the same cycle; the load wins. Outputs stay stable while out_valid & ~out_ready.
- Back-to-back: with out_ready=1 and mem_ready=1 continuously, one single-word instruction per cycle.
- flush=1 (highest priority after rst):
  - out_valid<=0, state<=F1, first-word latch discarded.
  - IPC=DIPC=0 and mem_req=0 that cycle.
  - Any mem_ready in that cycle is ignored.
  - Fetching resumes next cycle from the new pc_addr.
- bb=1: mem_req=0, no state change, and the output register still drains normally.
- mem_ready while mem_req=0: ignored.

Test Plan:
- Reset, pc_addr=0x0000, mem returns 0x1234 with mem_ready=1, out_ready=1 -> IPC pulse in cycle 1; next cycle out_valid=1, out_instr=0x1234, out_pc=0x0000, out_od=0.
- OD: pc_addr=0x0010, mem returns 0x8005 then 0xBEEF -> first cycle mem_addr=0x0010, no IPC; second cycle mem_addr=0x0011 with DIPC=1; then out_instr=0x8005, out_operand=0xBEEF, out_od=1, out_pc=0x0010.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> mem_req=0, no IPC/DIPC, outputs unchanged; out_ready=1 -> mem_req rises the same cycle.
- Flush in F2 with mem_ready=1 in the same cycle -> no DIPC, out_valid=0, state F1; next mem_addr equals the new pc_addr (e.g. 0x0040).
- bb=1 for 2 cycles with mem_ready=1 -> mem_req=0, IPC=0; fetch resumes when bb=0.
- Wrap: F2 with pc_addr=0xFFFF -> mem_addr=0x0000. rst asserted mid-F2 -> outputs return to their reset values next cycle.
